// File: rtl/time_set.sv
// Front-panel setting controller: three debounced keys drive a mode FSM that
// edits the time (shadow digits feeding the time counter) and the alarm.

// Per-key debouncer: 2-flop synchroniser, stability counter, press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);
  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic          s1, s2, level;
  logic [CW-1:0] cnt;

  // Accept a new level only after DEBOUNCE_CYC consecutive differing samples;
  // the pulse fires on the same edge the level rises, never on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      pulse <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        level <= s2;
        cnt   <= '0;
        pulse <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module time_set #(
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_sel,
  input  logic       key_inc,
  input  logic [3:0] cur_sec_ge,
  input  logic [3:0] cur_sec_shi,
  input  logic [3:0] cur_min_ge,
  input  logic [3:0] cur_min_shi,
  input  logic [3:0] cur_hour_ge,
  input  logic [3:0] cur_hour_shi,
  output logic [3:0] set_sec_ge,
  output logic [3:0] set_sec_shi,
  output logic [3:0] set_min_ge,
  output logic [3:0] set_min_shi,
  output logic [3:0] set_hour_ge,
  output logic [3:0] set_hour_shi,
  output logic       set_time_finish,
  output logic [3:0] clock_min_ge,
  output logic [3:0] clock_min_shi,
  output logic [3:0] clock_hour_ge,
  output logic [3:0] clock_hour_shi,
  output logic       clock_en,
  output logic [1:0] edit_mode,
  output logic [1:0] edit_field
);
  typedef enum logic [1:0] {IDLE = 2'd0, SET_TIME = 2'd1, SET_ALARM = 2'd2} state_t;

  state_t     state, state_nxt;
  logic [2:0] raw, pulse;
  logic       p_mode, p_sel, p_inc;
  logic [1:0] field, field_nxt;
  // Digit pairs packed as {shi, ge}.
  logic [7:0] hr, mn, sc, a_hr, a_mn;
  logic [7:0] hr_n, mn_n, sc_n, a_hr_n, a_mn_n;
  logic       en_n, fin_n;

  assign raw = {key_mode, key_sel, key_inc};

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_key
      key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (raw[g]),
        .pulse (pulse[g])
      );
    end
  endgenerate

  assign {p_mode, p_sel, p_inc} = pulse;

  // Seconds/minutes: 59 wraps to 00, anything out of range goes to 00.
  function automatic logic [7:0] inc_ms(input logic [3:0] shi, input logic [3:0] ge);
    if (shi > 4'd5 || ge > 4'd9) return 8'h00;
    if (ge == 4'd9) return (shi == 4'd5) ? 8'h00 : {shi + 4'd1, 4'd0};
    return {shi, ge + 4'd1};
  endfunction

  // Hours: 23 and anything beyond wrap to 00.
  function automatic logic [7:0] inc_hr(input logic [3:0] shi, input logic [3:0] ge);
    if (shi > 4'd2 || ge > 4'd9 || (shi == 4'd2 && ge >= 4'd3)) return 8'h00;
    if (ge == 4'd9) return {shi + 4'd1, 4'd0};
    return {shi, ge + 4'd1};
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and edit actions; if/else order gives mode > sel > inc.
  always_comb begin
    state_nxt = state;
    field_nxt = field;
    hr_n      = hr;
    mn_n      = mn;
    sc_n      = sc;
    a_hr_n    = a_hr;
    a_mn_n    = a_mn;
    en_n      = clock_en;
    fin_n     = 1'b0;
    case (state)
      IDLE: begin
        if (p_mode) begin
          state_nxt = SET_TIME;
          field_nxt = 2'd0;
          hr_n      = {cur_hour_shi, cur_hour_ge};
          mn_n      = {cur_min_shi, cur_min_ge};
          sc_n      = {cur_sec_shi, cur_sec_ge};
        end else if (p_inc) begin
          en_n = ~clock_en;
        end
      end
      SET_TIME: begin
        if (p_mode) begin
          state_nxt = SET_ALARM;
          field_nxt = 2'd0;
          fin_n     = 1'b1;
        end else if (p_sel) begin
          field_nxt = (field == 2'd2) ? 2'd0 : field + 2'd1;
        end else if (p_inc) begin
          case (field)
            2'd0:    hr_n = inc_hr(hr[7:4], hr[3:0]);
            2'd1:    mn_n = inc_ms(mn[7:4], mn[3:0]);
            default: sc_n = inc_ms(sc[7:4], sc[3:0]);
          endcase
        end
      end
      SET_ALARM: begin
        if (p_mode) begin
          state_nxt = IDLE;
        end else if (p_sel) begin
          field_nxt = (field == 2'd0) ? 2'd1 : 2'd0;
        end else if (p_inc) begin
          if (field == 2'd0) a_hr_n = inc_hr(a_hr[7:4], a_hr[3:0]);
          else               a_mn_n = inc_ms(a_mn[7:4], a_mn[3:0]);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow time, alarm, enable and load-strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      field           <= 2'd0;
      hr              <= 8'h00;
      mn              <= 8'h00;
      sc              <= 8'h00;
      a_hr            <= 8'h00;
      a_mn            <= 8'h00;
      clock_en        <= 1'b0;
      set_time_finish <= 1'b0;
    end else begin
      field           <= field_nxt;
      hr              <= hr_n;
      mn              <= mn_n;
      sc              <= sc_n;
      a_hr            <= a_hr_n;
      a_mn            <= a_mn_n;
      clock_en        <= en_n;
      set_time_finish <= fin_n;
    end
  end

  assign {set_hour_shi, set_hour_ge}     = hr;
  assign {set_min_shi, set_min_ge}       = mn;
  assign {set_sec_shi, set_sec_ge}       = sc;
  assign {clock_hour_shi, clock_hour_ge} = a_hr;
  assign {clock_min_shi, clock_min_ge}   = a_mn;
  assign edit_mode                       = state;
  assign edit_field                      = field;
endmodule

// File: tb/tb_time_set.sv
// Bench for time_set: debounce timing, table of increment/wrap vectors,
// hand-written commit/alarm/priority/reset sequences and random key traffic
// checked against an arithmetic model of the panel.
module tb_time_set;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  logic key_mode, key_sel, key_inc;
  logic [3:0] cur_sec_ge, cur_sec_shi, cur_min_ge, cur_min_shi, cur_hour_ge, cur_hour_shi;
  logic [3:0] set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi;
  logic       set_time_finish;
  logic [3:0] clock_min_ge, clock_min_shi, clock_hour_ge, clock_hour_shi;
  logic       clock_en;
  logic [1:0] edit_mode, edit_field;

  time_set #(.DEBOUNCE_CYC(D)) dut (
    .clk(clk), .rst(rst),
    .key_mode(key_mode), .key_sel(key_sel), .key_inc(key_inc),
    .cur_sec_ge(cur_sec_ge), .cur_sec_shi(cur_sec_shi),
    .cur_min_ge(cur_min_ge), .cur_min_shi(cur_min_shi),
    .cur_hour_ge(cur_hour_ge), .cur_hour_shi(cur_hour_shi),
    .set_sec_ge(set_sec_ge), .set_sec_shi(set_sec_shi),
    .set_min_ge(set_min_ge), .set_min_shi(set_min_shi),
    .set_hour_ge(set_hour_ge), .set_hour_shi(set_hour_shi),
    .set_time_finish(set_time_finish),
    .clock_min_ge(clock_min_ge), .clock_min_shi(clock_min_shi),
    .clock_hour_ge(clock_hour_ge), .clock_hour_shi(clock_hour_shi),
    .clock_en(clock_en), .edit_mode(edit_mode), .edit_field(edit_field)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int fin_seen = 0;

  // Model: digits as plain integers, hour/min/sec order.
  int cd[6];     // current-time inputs driven by the bench
  int sd[6];     // expected shadow time
  int ad[4];     // expected alarm
  int m_mode, m_field, m_en, exp_fin = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // The load strobe must only ever appear alongside SET_ALARM.
  always @(negedge clk) begin
    if (set_time_finish === 1'b1) begin
      fin_seen++;
      chk("finish_with_mode2", {30'd0, edit_mode}, 32'd2);
    end
  end

  function automatic int nxt_ms(input int shi, input int ge);
    if (shi > 5 || ge > 9) return 0;
    return (shi * 10 + ge + 1) % 60;
  endfunction

  function automatic int nxt_hr(input int shi, input int ge);
    if (ge > 9 || shi * 10 + ge > 23) return 0;
    return (shi * 10 + ge + 1) % 24;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_field = 0; m_en = 0;
    foreach (sd[i]) sd[i] = 0;
    foreach (ad[i]) ad[i] = 0;
  endtask

  task automatic model_apply(input bit m, input bit s, input bit i);
    int v;
    case (m_mode)
      0: if (m) begin m_mode = 1; m_field = 0; sd = cd; end
         else if (i) m_en ^= 1;
      1: if (m) begin m_mode = 2; m_field = 0; exp_fin++; end
         else if (s) m_field = (m_field + 1) % 3;
         else if (i) begin
           if (m_field == 0) v = nxt_hr(sd[0], sd[1]);
           else v = nxt_ms(sd[2*m_field], sd[2*m_field+1]);
           sd[2*m_field] = v / 10; sd[2*m_field+1] = v % 10;
         end
      default: if (m) m_mode = 0;
         else if (s) m_field = 1 - m_field;
         else if (i) begin
           v = (m_field == 0) ? nxt_hr(ad[0], ad[1]) : nxt_ms(ad[2], ad[3]);
           ad[2*m_field] = v / 10; ad[2*m_field+1] = v % 10;
         end
    endcase
  endtask

  task automatic drive_cur();
    {cur_hour_shi, cur_hour_ge, cur_min_shi, cur_min_ge, cur_sec_shi, cur_sec_ge} =
      {4'(cd[0]), 4'(cd[1]), 4'(cd[2]), 4'(cd[3]), 4'(cd[4]), 4'(cd[5])};
  endtask

  task automatic set_cur(input logic [23:0] t);
    for (int k = 0; k < 6; k++) cd[k] = int'(t[23-4*k -: 4]);
    drive_cur();
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Press a key combination {mode,sel,inc} cleanly and let the model follow.
  task automatic press(input logic [2:0] k);
    {key_mode, key_sel, key_inc} = k;
    repeat (8) step();
    {key_mode, key_sel, key_inc} = 3'b000;
    repeat (8) step();
    model_apply(k[2], k[1], k[0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {key_mode, key_sel, key_inc} = 3'b000;
    repeat (2) step();
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [23:0] set_act();
    return {set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge};
  endfunction

  task automatic check_all(input string nm);
    @(negedge clk);
    chk({nm, "/mode"}, {30'd0, edit_mode}, 32'(m_mode));
    if (m_mode != 0) chk({nm, "/field"}, {30'd0, edit_field}, 32'(m_field));
    chk({nm, "/set"}, {8'd0, set_act()},
        {8'd0, 4'(sd[0]), 4'(sd[1]), 4'(sd[2]), 4'(sd[3]), 4'(sd[4]), 4'(sd[5])});
    chk({nm, "/alarm"}, {16'd0, clock_hour_shi, clock_hour_ge, clock_min_shi, clock_min_ge},
        {16'd0, 4'(ad[0]), 4'(ad[1]), 4'(ad[2]), 4'(ad[3])});
    chk({nm, "/en"}, {31'd0, clock_en}, 32'(m_en));
    chk({nm, "/fin_count"}, 32'(fin_seen), 32'(exp_fin));
  endtask

  typedef struct {
    logic [23:0] cur;   // hh:mm:ss as BCD nibbles
    int          nsel;  // field to edit
    logic [23:0] exp;   // set_* after one increment
  } vec_t;

  vec_t vt[8];

  initial begin
    int  seen, fs;
    logic [23:0] cap_set;
    logic [1:0]  cap_mode;
    logic [2:0]  k;

    vt[0] = '{24'h230000, 0, 24'h000000};
    vt[1] = '{24'h091500, 0, 24'h101500};
    vt[2] = '{24'h125930, 1, 24'h120030};
    vt[3] = '{24'h270000, 0, 24'h000000};
    vt[4] = '{24'h194559, 0, 24'h204559};
    vt[5] = '{24'h050859, 2, 24'h050800};
    vt[6] = '{24'h106905, 1, 24'h100005};
    vt[7] = '{24'h11223A, 2, 24'h112200};

    set_cur(24'h000000);
    do_reset();
    check_all("reset");

    // Glitch of D-1 cycles: no pulse.
    key_inc = 1'b1; repeat (3) step(); key_inc = 1'b0; repeat (10) step();
    check_all("glitch");

    // Exact press latency, then hold with no further toggle.
    key_inc = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk); chk("latency_T6_en", {31'd0, clock_en}, 32'd0);
    @(posedge clk); @(negedge clk); chk("latency_T7_en", {31'd0, clock_en}, 32'd1);
    repeat (20) @(negedge clk);
    chk("held_no_retoggle", {31'd0, clock_en}, 32'd1);
    step(); key_inc = 1'b0; repeat (10) step();
    m_en = 1;
    check_all("after_hold");

    // Increment/wrap vectors.
    foreach (vt[i]) begin
      do_reset();
      set_cur(vt[i].cur);
      press(3'b100);
      for (int s = 0; s < vt[i].nsel; s++) press(3'b010);
      press(3'b001);
      @(negedge clk);
      chk($sformatf("vec%0d_set", i), {8'd0, set_act()}, {8'd0, vt[i].exp});
      check_all($sformatf("vec%0d", i));
    end

    // Load and commit.
    do_reset();
    set_cur(24'h123456);
    press(3'b100);
    check_all("load");
    press(3'b010); press(3'b010);
    check_all("sel2");
    press(3'b001);
    check_all("inc_sec");
    key_mode = 1'b1; seen = 0; cap_set = '0; cap_mode = '0; fs = fin_seen;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (set_time_finish === 1'b1) begin
        seen++; cap_set = set_act(); cap_mode = edit_mode;
      end
    end
    step(); key_mode = 1'b0; repeat (8) step();
    model_apply(1'b1, 1'b0, 1'b0);
    chk("commit_pulses", 32'(seen), 32'd1);
    chk("commit_set", {8'd0, cap_set}, 32'h00123457);
    chk("commit_mode", {30'd0, cap_mode}, 32'd2);
    check_all("after_commit");

    // Alarm edit from reset.
    do_reset();
    set_cur(24'h000000);
    press(3'b100); press(3'b100);
    repeat (7) press(3'b001);
    press(3'b010);
    repeat (30) press(3'b001);
    fs = fin_seen;
    press(3'b100);
    @(negedge clk);
    chk("alarm_0730", {16'd0, clock_hour_shi, clock_hour_ge, clock_min_shi, clock_min_ge}, 32'h0730);
    chk("alarm_no_finish", 32'(fin_seen), 32'(fs));
    check_all("alarm");

    // Simultaneous mode+inc in SET_TIME.
    do_reset();
    set_cur(24'h083021);
    press(3'b100);
    press(3'b101);
    check_all("simul");

    // Reset mid-edit.
    do_reset();
    set_cur(24'h154210);
    press(3'b100); press(3'b001); press(3'b010); press(3'b001);
    check_all("pre_rst");
    fs = fin_seen;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_mid_mode", {30'd0, edit_mode}, 32'd0);
    chk("rst_mid_set", {8'd0, set_act()}, 32'd0);
    chk("rst_mid_en", {31'd0, clock_en}, 32'd0);
    step(); rst = 1'b0; model_reset();
    repeat (3) step();
    chk("rst_mid_no_finish", 32'(fin_seen), 32'(fs));
    check_all("post_rst");

    // Random key traffic, including coincident presses.
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int d = 0; d < 6; d++) cd[d] = int'($urandom_range(0, 15));
      end else begin
        int h, mi, se;
        h = int'($urandom_range(0, 23)); mi = int'($urandom_range(0, 59)); se = int'($urandom_range(0, 59));
        cd[0] = h / 10; cd[1] = h % 10; cd[2] = mi / 10; cd[3] = mi % 10; cd[4] = se / 10; cd[5] = se % 10;
      end
      drive_cur();
      case ($urandom_range(0, 9))
        0, 1:    k = 3'b100;
        2, 3:    k = 3'b010;
        4, 5, 6: k = 3'b001;
        default: k = 3'($urandom_range(1, 7));
      endcase
      press(k);
      check_all($sformatf("rnd%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/time_set.md
# time_set

Front-panel setting controller for the digital clock. It debounces three push-buttons and runs a mode FSM that edits the time and the alarm as BCD digits. It drives the time counter's `set_*` digit bus and one-cycle `set_time_finish` load strobe, plus the alarm digits and `clock_en`. It sits directly upstream of the time counter and reads the counter's current digits back so that editing starts from the displayed time.

## Interface
- `DEBOUNCE_CYC`, default 20000: consecutive stable cycles required to accept a level change on a key.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `key_mode`, `key_sel`, `key_inc`  in  1 each  raw asynchronous buttons, 1 = pressed.
- `cur_sec_ge`, `cur_sec_shi`, `cur_min_ge`, `cur_min_shi`, `cur_hour_ge`, `cur_hour_shi`  in  4 each  current time digits from the time counter.
- `set_sec_ge`, `set_sec_shi`, `set_min_ge`, `set_min_shi`, `set_hour_ge`, `set_hour_shi`  out  4 each  edited time digits.
- `set_time_finish`  out  1  one-cycle load strobe to the time counter.
- `clock_min_ge`, `clock_min_shi`, `clock_hour_ge`, `clock_hour_shi`  out  4 each  alarm digits.
- `clock_en`  out  1  alarm enable.
- `edit_mode`  out  2  0 = IDLE, 1 = SET_TIME, 2 = SET_ALARM; drives the display blink.
- `edit_field`  out  2  selected field: 0 = hour, 1 = minute, 2 = second.

## Operation
- Key path, per key:
  - Two-flop synchroniser, then a stability counter.
  - The debounced level changes after the synchronised input has differed from it for `DEBOUNCE_CYC` consecutive cycles.
  - A 0->1 change of the debounced level produces a one-cycle press pulse.
  - Release never produces a pulse.
- Priority when pulses coincide in one cycle: `key_mode` > `key_sel` > `key_inc`. Lower-priority pulses in that cycle are dropped.
- FSM states: IDLE, SET_TIME, SET_ALARM.
- IDLE:
  - mode -> SET_TIME. The shadow time registers load from `cur_*` and `edit_field` becomes 0.
  - inc toggles `clock_en`.
  - sel is ignored.
- SET_TIME:
  - sel cycles `edit_field` 0 -> 1 -> 2 -> 0.
  - inc increments the selected field.
  - mode asserts `set_time_finish` for exactly one cycle, goes to SET_ALARM, and sets `edit_field` to 0.
- SET_ALARM:
  - sel cycles `edit_field` 0 -> 1 -> 0.
  - inc increments the selected alarm field.
  - mode -> IDLE.
- Field increment rules (BCD; no carry into neighbouring fields):
  - Seconds and minutes: ge 9 -> 0 with shi+1; 59 -> 00.
  - Hours: 09 -> 10, 19 -> 20, 23 -> 00.
  - Any out-of-range loaded value (shi > 5 for seconds/minutes, hour > 23, ge > 9) increments to 00.
- `set_*` always reflect the shadow time registers. They are stable from the cycle `set_time_finish` is high until the next entry into SET_TIME. Upper bits of tens digits are zero after any increment.
- Alarm digits and `clock_en` hold their values across all modes except as edited above.

## Timing
- Reset values:
  - State IDLE; `edit_mode` 0; `edit_field` 0.
  - All `set_*` 0; all `clock_*` digits 0; `clock_en` 0; `set_time_finish` 0.
  - Synchronisers, stability counters and debounced levels 0.
- Reset mid-edit discards the edit; no `set_time_finish` is issued.
- Press latency: a raw key rising at cycle T, held stable, gives a press pulse at cycle T+2+`DEBOUNCE_CYC`.
- Registered effects (field, digit, `clock_en`, state, `cur_*` capture) are visible the cycle after the press pulse.
- `set_time_finish` is high in the cycle after the mode pulse in SET_TIME, coincident with `edit_mode` = 2. `set_*` carry the final values in that cycle.
- Glitches shorter than `DEBOUNCE_CYC` cycles produce no pulse.
- A key held indefinitely produces exactly one pulse.

## Test plan
Run all scenarios with `DEBOUNCE_CYC` = 4.
- Debounce: raw `key_inc` 1 for 3 cycles then 0 -> no pulse, `clock_en` stays 0. Raw held 1 from cycle T -> pulse at T+6, `clock_en` = 1 at T+7, and no further toggle while held.
- Load and commit:
  - `cur_*` = 12:34:56; press mode -> `set_*` = 12:34:56, `edit_mode` = 1.
  - sel twice -> `edit_field` = 2; inc -> seconds 57.
  - mode -> `set_time_finish` high exactly one cycle with `set_*` = 12:34:57, `edit_mode` = 2.
- Wrap-around: hour 23 + inc -> 00; hour 09 + inc -> 10; minute 59 + inc -> 00 with hour unchanged; loaded hour 2,7 (invalid) + inc -> 00.
- Alarm edit:
  - In SET_ALARM from reset, inc×7 on hour -> alarm hour 07; sel, inc×30 -> alarm minute 30.
  - mode -> `edit_mode` = 0; `clock_*` hold 07:30; `set_time_finish` stays 0.
- Simultaneous keys: mode and inc pulses in the same cycle in SET_TIME -> state moves to SET_ALARM, no digit changes, one `set_time_finish`.
- Reset mid-edit: `rst` asserted in SET_TIME after edits -> next cycle `edit_mode` = 0, all `set_*` and `clock_*` = 0, `clock_en` = 0, `set_time_finish` never asserted.
